// File: rtl/lms_tx.sv
// LMS TX serialiser: buffers packed {I,Q} samples in a small FIFO and drives
// them onto the 12-bit TX bus as interleaved I/Q words, one word per clock.
module lms_tx #(
  parameter int FIFO_AW        = 2,
  parameter bit UNDERFLOW_ZERO = 1'b1
) (
  input  logic               mclk_tx,
  input  logic               rst,
  input  logic [23:0]        data_Ih_Ql,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic               en_tx,
  output logic [11:0]        dio_tx,
  output logic               iqsel_tx,
  output logic               txen_tx,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        underflow_cnt
);

  localparam int DATA_W = 12;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = DEPTH[FIFO_AW:0];

  typedef enum logic [1:0] {IDLE, PH_I, PH_Q} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [23:0]              mem_q [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]         level_q, level_d;
  logic                     ready_q, ready_d;
  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] hold_i_q, hold_i_d, hold_q_q, hold_q_d;
  logic signed [DATA_W-1:0] dio_q, dio_d;
  logic                     iqsel_q, iqsel_d, txen_q, txen_d;
  logic [15:0]              underflow_cnt_q, underflow_cnt_d;
  logic                     push, pop, empty;
  logic [23:0]              head;

  always_comb begin
    state_d         = state_q;
    hold_i_d        = hold_i_q;
    hold_q_d        = hold_q_q;
    dio_d           = dio_q;
    iqsel_d         = iqsel_q;
    underflow_cnt_d = underflow_cnt_q;
    pop             = 1'b0;
    head            = mem_q[rd_ptr_q];
    empty           = (level_q == '0);
    push            = data_valid && ready_q;

    // The state names the word currently on the bus; each decision picks the next word.
    case (state_q)
      IDLE: begin
        dio_d   = '0;
        iqsel_d = 1'b1;
        if (en_tx && !empty) begin
          pop      = 1'b1;
          hold_i_d = head[23:12];
          hold_q_d = head[11:0];
          dio_d    = head[23:12];
          iqsel_d  = 1'b0;
          state_d  = PH_I;
        end
      end
      PH_I: begin
        dio_d   = hold_q_q;
        iqsel_d = 1'b1;
        state_d = PH_Q;
      end
      PH_Q: begin
        if (!en_tx) begin
          dio_d   = '0;
          iqsel_d = 1'b1;
          state_d = IDLE;
        end else if (!empty) begin
          pop      = 1'b1;
          hold_i_d = head[23:12];
          hold_q_d = head[11:0];
          dio_d    = head[23:12];
          iqsel_d  = 1'b0;
          state_d  = PH_I;
        end else begin
          if (UNDERFLOW_ZERO) begin
            hold_i_d = '0;
            hold_q_d = '0;
          end
          dio_d           = hold_i_d;
          iqsel_d         = 1'b0;
          underflow_cnt_d = sat_inc(underflow_cnt_q);
          state_d         = PH_I;
        end
      end
      default: begin
        dio_d   = '0;
        iqsel_d = 1'b1;
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ready_d = (level_d != DEPTH_L);
    txen_d  = (state_d != IDLE);
  end

  always_ff @(posedge mclk_tx) begin
    if (push) mem_q[wr_ptr_q] <= data_Ih_Ql;
  end

  always_ff @(posedge mclk_tx) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      ready_q         <= 1'b1;
      state_q         <= IDLE;
      hold_i_q        <= '0;
      hold_q_q        <= '0;
      dio_q           <= '0;
      iqsel_q         <= 1'b1;
      txen_q          <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      ready_q         <= ready_d;
      state_q         <= state_d;
      hold_i_q        <= hold_i_d;
      hold_q_q        <= hold_q_d;
      dio_q           <= dio_d;
      iqsel_q         <= iqsel_d;
      txen_q          <= txen_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign data_ready    = ready_q;
  assign dio_tx        = dio_q;
  assign iqsel_tx      = iqsel_q;
  assign txen_tx       = txen_q;
  assign fifo_level    = level_q;
  assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_lms_tx.sv
// Bench for lms_tx: a scoreboard queue of expected bus words, plus per-scenario
// inline checks on latency, backpressure, underflow fill and reset.
module tb_lms_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] din;
  logic        dv, en;

  logic        data_ready, iqsel_tx, txen_tx;
  logic [11:0] dio_tx;
  logic [2:0]  fifo_level;
  logic [15:0] underflow_cnt;

  logic        data_ready0, iqsel0, txen0;
  logic [11:0] dio0;
  logic [2:0]  level0;
  logic [15:0] cnt0;

  int          nvec = 0;
  int          nerr = 0;
  logic [12:0] exp_q [$];
  logic [12:0] e;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  lms_tx #(.FIFO_AW(2), .UNDERFLOW_ZERO(1'b1)) dut (
    .mclk_tx(clk), .rst(rst), .data_Ih_Ql(din), .data_valid(dv),
    .data_ready(data_ready), .en_tx(en), .dio_tx(dio_tx), .iqsel_tx(iqsel_tx),
    .txen_tx(txen_tx), .fifo_level(fifo_level), .underflow_cnt(underflow_cnt)
  );

  lms_tx #(.FIFO_AW(2), .UNDERFLOW_ZERO(1'b0)) dut0 (
    .mclk_tx(clk), .rst(rst), .data_Ih_Ql(din), .data_valid(dv),
    .data_ready(data_ready0), .en_tx(en), .dio_tx(dio0), .iqsel_tx(iqsel0),
    .txen_tx(txen0), .fifo_level(level0), .underflow_cnt(cnt0)
  );

  // Scoreboard: every word on the bus during a transfer must be the next expected one.
  always @(negedge clk) begin
    if (mon_en) begin
      nvec++;
      if (txen_tx) begin
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL sb_extra: got iq=%0b dio=%h, expected no word", iqsel_tx, dio_tx);
        end else begin
          e = exp_q.pop_front();
          if ({iqsel_tx, dio_tx} !== e) begin
            nerr++;
            $display("FAIL sb_word: got iq=%0b dio=%h, expected iq=%0b dio=%h",
                     iqsel_tx, dio_tx, e[12], e[11:0]);
          end
        end
      end else if ({iqsel_tx, dio_tx} !== 13'h1000) begin
        nerr++;
        $display("FAIL idle_bus: got iq=%0b dio=%h, expected iq=1 dio=000", iqsel_tx, dio_tx);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1; dv = 1'b0; en = 1'b0; din = '0;
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push_sample(input logic [23:0] d);
    int t;
    din = d; dv = 1'b1;
    exp_q.push_back({1'b0, d[23:12]});
    exp_q.push_back({1'b1, d[11:0]});
    t = 0;
    while (!data_ready && t < 100) begin tick(); t++; end
    nvec++;
    if (t >= 100) begin nerr++; $display("FAIL push_timeout: data_ready=%0b after %0d cycles, expected 1", data_ready, t); end
    tick();
  endtask

  task automatic drain_stop();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge clk); #1; t++; end
    nvec++;
    if (exp_q.size() != 0) begin nerr++; $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size()); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (dio_tx !== 12'h000) begin nerr++; $display("FAIL rst_dio: got %h, expected 000", dio_tx); end
    nvec++; if (iqsel_tx !== 1'b1) begin nerr++; $display("FAIL rst_iqsel: got %0b, expected 1", iqsel_tx); end
    nvec++; if (txen_tx !== 1'b0) begin nerr++; $display("FAIL rst_txen: got %0b, expected 0", txen_tx); end
    nvec++; if (data_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %0b, expected 1", data_ready); end
    nvec++; if (fifo_level !== 3'd0) begin nerr++; $display("FAIL rst_level: got %0d, expected 0", fifo_level); end
    nvec++; if (underflow_cnt !== 16'd0) begin nerr++; $display("FAIL rst_cnt: got %h, expected 0000", underflow_cnt); end
    nvec++; if ({iqsel0, dio0, txen0} !== 14'h2000) begin nerr++; $display("FAIL rst_dut0: got iq=%0b dio=%h txen=%0b, expected 1/000/0", iqsel0, dio0, txen0); end
  endtask

  task automatic test_single();
    do_reset();
    mon_en = 1'b1;
    en = 1'b1; din = 24'h123456; dv = 1'b1;
    exp_q.push_back({1'b0, 12'h123});
    exp_q.push_back({1'b1, 12'h456});
    tick(); dv = 1'b0;
    nvec++; if ({txen_tx, fifo_level} !== 4'b0001) begin nerr++; $display("FAIL single_accept: got txen=%0b level=%0d, expected 0/1", txen_tx, fifo_level); end
    tick();
    nvec++; if ({iqsel_tx, dio_tx} !== 13'h0123) begin nerr++; $display("FAIL single_i: got iq=%0b dio=%h, expected 0/123", iqsel_tx, dio_tx); end
    exp_q.push_back(13'h0000);
    exp_q.push_back(13'h1000);
    tick();
    nvec++; if ({iqsel_tx, dio_tx} !== 13'h1456) begin nerr++; $display("FAIL single_q: got iq=%0b dio=%h, expected 1/456", iqsel_tx, dio_tx); end
    tick();
    nvec++; if (underflow_cnt !== 16'd1) begin nerr++; $display("FAIL single_ucnt: got %0d, expected 1", underflow_cnt); end
    en = 1'b0;
    tick(); tick();
    nvec++; if ({txen_tx, iqsel_tx, dio_tx} !== 14'h1000) begin nerr++; $display("FAIL single_idle: got txen=%0b iq=%0b dio=%h, expected 0/1/000", txen_tx, iqsel_tx, dio_tx); end
    nvec++; if (underflow_cnt !== 16'd1 || exp_q.size() != 0) begin nerr++; $display("FAIL single_end: got cnt=%0d left=%0d, expected 1/0", underflow_cnt, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mon_en = 1'b1;
    en = 1'b1;
    for (int n = 0; n < 8; n++) push_sample(24'(24'hA00B00 + n * 24'h001001));
    dv = 1'b0;
    drain_stop();
    nvec++; if (underflow_cnt !== 16'd0) begin nerr++; $display("FAIL b2b_ucnt: got %0d, expected 0", underflow_cnt); end
    nvec++; if (txen_tx !== 1'b0) begin nerr++; $display("FAIL b2b_idle: got txen=%0b, expected 0", txen_tx); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mon_en = 1'b1;
    for (int n = 0; n < 4; n++) push_sample(24'(24'h100200 + n * 24'h011011));
    nvec++; if (data_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_ready: got %0b, expected 0", data_ready); end
    nvec++; if (fifo_level !== 3'd4) begin nerr++; $display("FAIL bp_full_level: got %0d, expected 4", fifo_level); end
    din = 24'hC0DE55; dv = 1'b1;
    exp_q.push_back({1'b0, 12'hC0D});
    exp_q.push_back({1'b1, 12'hE55});
    tick(); tick();
    nvec++; if ({data_ready, fifo_level} !== 4'b0100) begin nerr++; $display("FAIL bp_held: got ready=%0b level=%0d, expected 0/4", data_ready, fifo_level); end
    en = 1'b1;
    tick();
    nvec++; if ({data_ready, fifo_level} !== 4'b1011) begin nerr++; $display("FAIL bp_after_pop: got ready=%0b level=%0d, expected 1/3", data_ready, fifo_level); end
    tick(); dv = 1'b0;
    nvec++; if ({data_ready, fifo_level} !== 4'b0100) begin nerr++; $display("FAIL bp_fifth_in: got ready=%0b level=%0d, expected 0/4", data_ready, fifo_level); end
    drain_stop();
    nvec++; if ({txen_tx, fifo_level} !== 4'b0000) begin nerr++; $display("FAIL bp_end: got txen=%0b level=%0d, expected 0/0", txen_tx, fifo_level); end
  endtask

  task automatic test_underflow_repeat();
    do_reset();
    en = 1'b1; din = 24'h7FF800; dv = 1'b1;
    tick(); dv = 1'b0;
    tick();
    nvec++; if ({iqsel0, dio0} !== 13'h07FF) begin nerr++; $display("FAIL ur_i: got iq=%0b dio=%h, expected 0/7FF", iqsel0, dio0); end
    tick();
    nvec++; if ({iqsel0, dio0} !== 13'h1800) begin nerr++; $display("FAIL ur_q: got iq=%0b dio=%h, expected 1/800", iqsel0, dio0); end
    for (int p = 1; p <= 3; p++) begin
      tick();
      nvec++; if ({iqsel0, dio0} !== 13'h07FF || cnt0 !== 16'(p)) begin nerr++; $display("FAIL ur_rep_i: got iq=%0b dio=%h cnt=%0d, expected 0/7FF/%0d", iqsel0, dio0, cnt0, p); end
      if (p == 1) begin
        nvec++; if ({iqsel_tx, dio_tx} !== 13'h0000) begin nerr++; $display("FAIL uz_fill: got iq=%0b dio=%h, expected 0/000", iqsel_tx, dio_tx); end
      end
      tick();
      nvec++; if ({iqsel0, dio0} !== 13'h1800) begin nerr++; $display("FAIL ur_rep_q: got iq=%0b dio=%h, expected 1/800", iqsel0, dio0); end
    end
    tick();
    force dut0.underflow_cnt_d = 16'hFFFE;
    tick();
    release dut0.underflow_cnt_d;
    repeat (8) tick();
    nvec++; if (cnt0 !== 16'hFFFF) begin nerr++; $display("FAIL sat_reach: got %h, expected FFFF", cnt0); end
    repeat (8) tick();
    nvec++; if (cnt0 !== 16'hFFFF) begin nerr++; $display("FAIL sat_hold: got %h, expected FFFF", cnt0); end
    en = 1'b0;
    tick(); tick();
    do_reset();
    nvec++; if (cnt0 !== 16'd0) begin nerr++; $display("FAIL sat_rst: got %h, expected 0000", cnt0); end
  endtask

  task automatic test_en_drop_and_reset();
    do_reset();
    mon_en = 1'b1;
    en = 1'b1; din = 24'h321654; dv = 1'b1;
    exp_q.push_back({1'b0, 12'h321});
    exp_q.push_back({1'b1, 12'h654});
    tick(); dv = 1'b0;
    tick();
    nvec++; if ({iqsel_tx, dio_tx} !== 13'h0321) begin nerr++; $display("FAIL drop_i: got iq=%0b dio=%h, expected 0/321", iqsel_tx, dio_tx); end
    en = 1'b0;
    tick();
    nvec++; if ({txen_tx, iqsel_tx, dio_tx} !== 14'h3654) begin nerr++; $display("FAIL drop_q: got txen=%0b iq=%0b dio=%h, expected 1/1/654", txen_tx, iqsel_tx, dio_tx); end
    tick();
    nvec++; if ({txen_tx, iqsel_tx, dio_tx} !== 14'h1000 || exp_q.size() != 0) begin nerr++; $display("FAIL drop_idle: got txen=%0b iq=%0b dio=%h left=%0d, expected 0/1/000/0", txen_tx, iqsel_tx, dio_tx, exp_q.size()); end
    en = 1'b1; din = 24'hAAA555; dv = 1'b1;
    exp_q.push_back({1'b0, 12'hAAA});
    exp_q.push_back({1'b1, 12'h555});
    tick();
    din = 24'hBBB666;
    tick();
    nvec++; if ({txen_tx, fifo_level} !== 4'b1001) begin nerr++; $display("FAIL mid_pre: got txen=%0b level=%0d, expected 1/1", txen_tx, fifo_level); end
    mon_en = 1'b0; rst = 1'b1; dv = 1'b0;
    exp_q.delete();
    tick();
    nvec++; if ({txen_tx, iqsel_tx, dio_tx} !== 14'h1000) begin nerr++; $display("FAIL mid_bus: got txen=%0b iq=%0b dio=%h, expected 0/1/000", txen_tx, iqsel_tx, dio_tx); end
    nvec++; if ({data_ready, fifo_level, underflow_cnt} !== {1'b1, 3'd0, 16'd0}) begin nerr++; $display("FAIL mid_state: got ready=%0b level=%0d cnt=%0d, expected 1/0/0", data_ready, fifo_level, underflow_cnt); end
    rst = 1'b0;
    tick(); tick();
    nvec++; if (txen_tx !== 1'b0) begin nerr++; $display("FAIL mid_flush: got txen=%0b, expected 0", txen_tx); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dv = 1'b0; en = 1'b0; din = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_underflow_repeat();
    test_en_drop_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
